// File: rtl/im_loader.sv
// Boot-time program loader: assembles a framed byte stream into 32-bit words, writes them
// to instruction memory from address 0, verifies an XOR checksum and then releases the core.
module im_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  asyn_rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [WORD_WIDTH-1:0] im_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [7:0]            len_q;
    logic [7:0]            word_q;
    logic [1:0]            bcnt_q;
    logic [7:0]            acc_q;
    logic [23:0]           shift_q;
    logic                  ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  run_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  xfer;

    // A start pulse masks the handshake so a coincident byte is never consumed.
    assign in_ready = ready_q & ~start;
    assign xfer     = in_valid & in_ready;

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign cpu_run  = run_q;
    assign busy     = busy_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                state_q <= S_LEN;
                ready_q <= 1'b1;
                busy_q  <= 1'b1;
                run_q   <= 1'b0;
                err_q   <= 1'b0;
                word_q  <= '0;
                bcnt_q  <= '0;
                acc_q   <= '0;
            end else begin
                case (state_q)
                    S_LEN: if (xfer) begin
                        len_q   <= in_data;
                        word_q  <= '0;
                        bcnt_q  <= '0;
                        acc_q   <= '0;
                        state_q <= S_DATA;
                    end
                    S_DATA: if (xfer) begin
                        shift_q <= {shift_q[15:0], in_data};
                        acc_q   <= acc_q ^ in_data;
                        bcnt_q  <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= WORD_WIDTH'({shift_q, in_data});
                            addr_q  <= ADDR_WIDTH'(word_q);
                            word_q  <= word_q + 8'd1;
                            if (word_q == len_q) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: if (xfer) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (in_data == acc_q) begin
                            state_q <= S_DONE;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: a frame-level model predicts writes and status; checked every cycle.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        asyn_rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_run;
    logic        busy;
    logic        err;

    im_loader #(.ADDR_WIDTH(8), .WORD_WIDTH(32)) dut (
        .clk      (clk),
        .asyn_rst (asyn_rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  frame[$];
    int          m_pos = 0;
    logic [7:0]  m_xor = '0;
    logic        m_busy = 1'b0;
    logic        m_run = 1'b0;
    logic        m_err = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          nwrites = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the frame model.
    initial begin : cmp
        wr_t w;
        forever begin
            @(negedge clk);
            #2;
            chk("in_ready", in_ready, m_busy & ~start);
            chk("busy", busy, m_busy);
            chk("cpu_run", cpu_run, m_run);
            chk("err", err, m_err);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("im_we", im_we, 1);
                chk("im_addr", im_addr, w.addr);
                chk("im_wdata", im_wdata, w.data);
            end else begin
                chk("im_we_idle", im_we, 0);
            end
            if (im_we === 1'b1) begin
                nwrites++;
                last_addr = im_addr;
                last_data = im_wdata;
            end
        end
    end

    // Frame model: byte 0 is LEN, then 4*(LEN+1) payload bytes, then CHK.
    task automatic accept_byte(input logic [7:0] b);
        int k = m_pos;
        if (k == 0) begin
            m_xor = '0;
        end else if (k <= 4 * (int'(frame[0]) + 1)) begin
            m_xor ^= b;
            if (k % 4 == 0)
                exp_q.push_back('{addr: 8'(k / 4 - 1), data: {frame[k-3], frame[k-2], frame[k-1], b}});
        end else begin
            m_busy = 1'b0;
            m_run  = (b == m_xor);
            m_err  = (b != m_xor);
        end
        m_pos++;
    endtask

    task automatic do_start(input logic v, input logic [7:0] d);
        @(negedge clk);
        start = 1'b1; in_valid = v; in_data = d;
        #1;
        chk("start_masks_ready", in_ready, 0);
        @(posedge clk);
        m_busy = 1'b1; m_run = 1'b0; m_err = 1'b0; m_pos = 0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send(input int n, input int gap, output int cycles);
        int  sent = 0;
        logic acc;
        cycles = 0;
        while (sent < n) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = frame[m_pos];
            end
            #1;
            acc = in_valid & in_ready;
            @(posedge clk);
            if (acc) begin
                accept_byte(frame[m_pos]);
                sent++;
            end
            cycles++;
            if (cycles > 5000) begin
                chk("send_timeout", sent, n);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic make_frame(input int len, input logic [7:0] base, input bit rnd, input bit bad);
        logic [7:0] x = '0;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(len));
        for (int i = 0; i < 4 * (len + 1); i++) begin
            b = rnd ? 8'($urandom) : 8'(base + 8'(i));
            x ^= b;
            frame.push_back(b);
        end
        frame.push_back(bad ? ~x : x);
    endtask

    task automatic frame_t1(input logic [7:0] chkbyte);
        logic [7:0] t1 [5] = '{8'h00, 8'h20, 8'h08, 8'h00, 8'h05};
        frame.delete();
        for (int i = 0; i < 5; i++) frame.push_back(t1[i]);
        frame.push_back(chkbyte);
    endtask

    initial begin : main
        int cyc;
        int base_w;
        asyn_rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        #3;
        chk("rst_addr", im_addr, 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_we", im_we, 0);
        asyn_rst = 1'b0;
        idle(2);

        // 1: single word, good checksum
        frame_t1(8'h2D);
        do_start(1'b0, 8'h00);
        send(6, 0, cyc);
        idle(3);
        chk("t1_nwrites", nwrites, 1);
        chk("t1_addr", last_addr, 8'h00);
        chk("t1_data", last_data, 32'h2008_0005);
        chk("t1_run", cpu_run, 1);
        chk("t1_err", err, 0);

        // 2: three words at full rate
        base_w = nwrites;
        make_frame(2, 8'h11, 1'b0, 1'b0);
        do_start(1'b0, 8'h00);
        send(14, 0, cyc);
        chk("t2_full_rate", cyc, 14);
        idle(3);
        chk("t2_nwrites", nwrites - base_w, 3);
        chk("t2_last_addr", last_addr, 8'h02);
        chk("t2_last_data", last_data, 32'h191A_1B1C);
        chk("t2_run", cpu_run, 1);

        // 3: bad checksum, then restart clears err
        frame_t1(8'h00);
        do_start(1'b0, 8'h00);
        send(6, 0, cyc);
        idle(3);
        chk("t3_err", err, 1);
        chk("t3_run", cpu_run, 0);
        do_start(1'b0, 8'h00);
        chk("t3_err_cleared", err, 0);
        chk("t3_busy", busy, 1);

        // 4: eight words with ~50% valid gaps
        base_w = nwrites;
        make_frame(7, 8'h00, 1'b1, 1'b0);
        send(34, 50, cyc);
        idle(3);
        chk("t4_nwrites", nwrites - base_w, 8);
        chk("t4_last_addr", last_addr, 8'h07);
        chk("t4_run", cpu_run, 1);

        // 5: abort after six payload bytes, start collides with a valid byte
        base_w = nwrites;
        make_frame(1, 8'h40, 1'b0, 1'b0);
        do_start(1'b0, 8'h00);
        send(7, 0, cyc);
        do_start(1'b1, frame[7]);
        chk("t5_partial_writes", nwrites - base_w, 1);
        chk("t5_partial_data", last_data, 32'h4041_4243);
        frame.delete();
        frame.push_back(8'h00);
        frame.push_back(8'hDE); frame.push_back(8'hAD);
        frame.push_back(8'hBE); frame.push_back(8'hEF);
        frame.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
        send(6, 0, cyc);
        idle(3);
        chk("t5_addr", last_addr, 8'h00);
        chk("t5_data", last_data, 32'hDEAD_BEEF);
        chk("t5_run", cpu_run, 1);

        // 6: asynchronous reset mid-DATA
        make_frame(3, 8'h80, 1'b0, 1'b0);
        do_start(1'b0, 8'h00);
        send(11, 0, cyc);
        @(negedge clk);
        #3;
        asyn_rst = 1'b1;
        m_busy = 1'b0; m_run = 1'b0; m_err = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_ready", in_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_we", im_we, 0);
        chk("t6_addr", im_addr, 0);
        chk("t6_wdata", im_wdata, 0);
        chk("t6_run", cpu_run, 0);
        chk("t6_err", err, 0);
        #4;
        asyn_rst = 1'b0;
        idle(4);
        frame_t1(8'h2D);
        do_start(1'b0, 8'h00);
        send(6, 0, cyc);
        idle(3);
        chk("t6_reload_data", last_data, 32'h2008_0005);
        chk("t6_reload_run", cpu_run, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
